bcd_to_bin_conv: RTL and testbench
==================================

Name: bcd_to_bin_conv

Overview:
- Downstream neighbour of the keypad input stage. Consumes its 36-bit packed digit register: 9 nibbles, most-significant digit in bcd[35:32], newest key in bcd[3:0].
- Converts the 9 decimal digits to an unsigned binary operand for the primality-test datapath.
- Works iteratively, MSB digit first: acc = acc*10 + digit.
- Uses a start/busy/done handshake. Flags any non-decimal nibble (keypad codes 0xC, 0xD, 0xF).

Parameters:
- DIGITS, 9, number of BCD nibbles in the input word.
- BIN_W, 30, result width. Must satisfy 10^DIGITS - 1 < 2^BIN_W; 999,999,999 < 2^30.

Ports:
- clk    input   1           system clock; all logic on the rising edge.
- rst    input   1           synchronous, active-high reset.
- start  input   1           request a conversion. Sampled only in IDLE.
- bcd    input   4*DIGITS    packed BCD digits, MSB nibble first. Captured on the accepted start.
- busy   output  1           high while in CONV.
- done   output  1           one-cycle pulse when a result is valid.
- err    output  1           valid with done. High if any nibble was > 9.
- bin    output  BIN_W       converted value. Held stable from done until the next accepted start.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. rst has priority over every other input, including mid-conversion.
- Reset values:
  - State machine returns to IDLE.
  - busy=0, done=0, err=0, bin=0.
  - Internal accumulator, digit counter and shift register = 0.
  - A conversion in flight is abandoned; no done pulse is produced for it.
- State machine:
  - IDLE: busy=0. On start=1, load shift register <= bcd, acc <= 0, cnt <= 0, err_int <= 0; go to CONV. Otherwise stay.
  - CONV: busy=1. Each cycle:
    - d = shreg[4*DIGITS-1 -: 4].
    - acc <= (acc<<3) + (acc<<1) + d, truncated to BIN_W.
    - shreg <= shreg << 4.
    - cnt <= cnt+1.
    - If d > 9: err_int <= 1, and d is still added (the result is discarded anyway).
    - When cnt == DIGITS-1, go to DONE.
  - DONE (exactly 1 cycle): busy=0, done=1.
    - bin <= err_int ? 0 : final acc; err <= err_int. Registered so that both are valid in the done cycle.
    - Next state is always IDLE.
- Latency: start accepted at edge N gives done=1 in the cycle after edge N+DIGITS+1. That is DIGITS+2 cycles start-to-done, and fixed, including on error.
- Handshake rules:
  - start is ignored in CONV and DONE (no queueing).
  - A new start is accepted the cycle after done.
  - start held continuously produces back-to-back conversions every DIGITS+2 cycles.
- Input capture: bcd may change after the accepted start without affecting the result.
- Arithmetic: acc is BIN_W bits. With the legal parameter constraint, no overflow is possible for valid digits. Leading zero nibbles contribute 0.
- err and bin keep their last values until the next DONE. done never asserts without a preceding accepted start.
- All-zero input yields bin=0, err=0. This is a valid result, not an error.

Test Plan:
- Reset, then start with bcd=36'h000000561 -> done exactly 11 cycles after the start edge; bin=561 (0x231), err=0; busy high for 9 cycles.
- bcd=36'h999999999 -> bin=999999999 (0x3B9AC9FF), err=0. Then bcd=36'h000000000 -> bin=0, err=0.
- bcd=36'h0000001D7 (enter key code embedded) -> done at the same latency; err=1, bin=0. A following start with 36'h000000007 -> bin=7, err=0.
- Start pulsed again at cycles 3 and 10 of a conversion, with bcd changed to 36'h123456789 after capture -> both ignored; the original result is reported; exactly one done pulse.
- rst asserted at CONV cycle 5 -> next cycle busy=0, done=0, bin=0, err=0. No done pulse follows. A new start with 36'h000000013 -> bin=13.
- start held high for 30 cycles with bcd=36'h000000042 -> done pulses at 11-cycle intervals, bin=42 each time; never two consecutive done cycles.

Source files
------------

// File: rtl/bcd_to_bin_conv_if.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_conv_if
// Handshake bundle between the keypad input stage (master) and the BCD to
// binary converter (slave).
//   start : request a conversion (master -> slave)
//   bcd   : packed BCD digits, most-significant nibble first (master -> slave)
//   busy  : converter is iterating over the digits (slave -> master)
//   done  : one-cycle pulse, bin/err valid (slave -> master)
//   err   : a nibble above 9 was seen, valid with done (slave -> master)
//   bin   : converted unsigned value, held until the next accepted start
// ---------------------------------------------------------------------------
interface bcd_to_bin_conv_if #(
   parameter int DIGITS = 9,
   parameter int BIN_W  = 30
);
   logic                  start;
   logic [4*DIGITS-1:0]   bcd;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [BIN_W-1:0]      bin;

   modport master (
      output start,
      output bcd,
      input  busy,
      input  done,
      input  err,
      input  bin
   );

   modport slave (
      input  start,
      input  bcd,
      output busy,
      output done,
      output err,
      output bin
   );
endinterface

// File: rtl/bcd_to_bin_conv.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_conv
// Iterative BCD to binary converter. Digits are consumed most-significant
// first, one per clock, with acc = acc*10 + digit. Non-decimal nibbles
// (keypad control codes) raise err and force bin to zero.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset, highest priority
//   conv : slave side of bcd_to_bin_conv_if (start/bcd in,
//          busy/done/err/bin out, all outputs registered)
// Timing: start accepted at edge N -> busy high for DIGITS cycles,
// done high in the cycle following edge N+DIGITS+1.
// ---------------------------------------------------------------------------
module bcd_to_bin_conv #(
   parameter int DIGITS = 9,
   parameter int BIN_W  = 30
) (
   input  logic               clk,
   input  logic               rst,
   bcd_to_bin_conv_if.slave   conv
);

   localparam int SH_W  = 4 * DIGITS;
   localparam int CNT_W = $clog2(DIGITS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // True when a nibble is not a decimal digit (0xA..0xF).
   function automatic logic nibble_invalid(input logic [3:0] nib);
      return (nib > 4'd9);
   endfunction

   // acc*10 + digit using two shifts, truncated to BIN_W.
   function automatic logic [BIN_W-1:0] mac10(input logic [BIN_W-1:0] acc,
                                              input logic [3:0]       nib);
      return (acc << 3) + (acc << 1) + {{(BIN_W-4){1'b0}}, nib};
   endfunction

   state_t             state_q,   state_d;
   logic [SH_W-1:0]    shreg_q,   shreg_d;
   logic [BIN_W-1:0]   acc_q,     acc_d;
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic               err_int_q, err_int_d;
   logic               busy_q,    busy_d;
   logic               done_q,    done_d;
   logic               err_q,     err_d;
   logic [BIN_W-1:0]   bin_q,     bin_d;
   logic [3:0]         digit_s;

   // Next-state and datapath computation for the IDLE/CONV/DONE sequence.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      err_int_d = err_int_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      bin_d     = bin_q;
      digit_s   = shreg_q[SH_W-1 -: 4];

      case (state_q)
         ST_IDLE: begin
            if (conv.start) begin
               // Capture the digits so later bcd changes cannot disturb us.
               shreg_d   = conv.bcd;
               acc_d     = '0;
               cnt_d     = '0;
               err_int_d = 1'b0;
               busy_d    = 1'b1;
               state_d   = ST_CONV;
            end else begin
               busy_d    = 1'b0;
               state_d   = ST_IDLE;
            end
         end

         ST_CONV: begin
            // Invalid digits are still accumulated; the value is dropped later.
            acc_d   = mac10(acc_q, digit_s);
            shreg_d = {shreg_q[SH_W-5:0], 4'h0};
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (nibble_invalid(digit_s)) begin
               err_int_d = 1'b1;
            end else begin
               err_int_d = err_int_q;
            end
            if (cnt_q == LAST_CNT) begin
               busy_d  = 1'b0;
               state_d = ST_DONE;
            end else begin
               busy_d  = 1'b1;
               state_d = ST_CONV;
            end
         end

         ST_DONE: begin
            // Result and flag are registered together with the done pulse.
            bin_d   = err_int_q ? {BIN_W{1'b0}} : acc_q;
            err_d   = err_int_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         err_int_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         bin_q     <= '0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         err_int_q <= err_int_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         bin_q     <= bin_d;
      end
   end

   assign conv.busy = busy_q;
   assign conv.done = done_q;
   assign conv.err  = err_q;
   assign conv.bin  = bin_q;

endmodule

// File: tb/tb_bcd_to_bin_conv.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_bin_conv
// Self-checking bench: directed cases plus randomized digit words checked
// against an arithmetic reference (value = sum of digit * 10^position).
// ---------------------------------------------------------------------------
module tb_bcd_to_bin_conv;

   localparam int DIGITS = 9;
   localparam int BIN_W  = 30;
   localparam int LAT    = DIGITS + 1;   // edges after the accepting edge

   logic clk = 1'b0;
   logic rst;

   int checks   = 0;
   int failures = 0;

   bcd_to_bin_conv_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) conv_if ();

   bcd_to_bin_conv #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk  (clk),
      .rst  (rst),
      .conv (conv_if)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: decimal value by positional weights, err if any nibble > 9.
   function automatic void ref_conv(input logic [4*DIGITS-1:0] b,
                                    output longint val, output bit e);
      longint weight;
      logic [3:0] d;
      val    = 0;
      e      = 1'b0;
      weight = 1;
      for (int i = 0; i < DIGITS; i++) begin
         d = b[4*i +: 4];
         if (d > 4'd9) e = 1'b1;
         val    = val + longint'(d) * weight;
         weight = weight * 10;
      end
      if (e) val = 0;
   endfunction

   // Start one conversion, watch it for 25 cycles and check everything.
   task automatic run_conv(input string tag, input logic [4*DIGITS-1:0] b,
                           input bit poke);
      longint     exp_val;
      bit         exp_err;
      int         busy_cnt;
      int         done_cnt;
      int         done_at;
      logic [63:0] r;
      ref_conv(b, exp_val, exp_err);
      conv_if.bcd   = b;
      conv_if.start = 1'b1;
      step();
      conv_if.start = 1'b0;
      busy_cnt = 0;
      done_cnt = 0;
      done_at  = -1;
      for (int k = 0; k < 25; k++) begin
         if (conv_if.busy) busy_cnt++;
         if (conv_if.done) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
            check_val({tag, "_bin"}, 64'(conv_if.bin), 64'(exp_val));
            check_val({tag, "_err"}, 64'(conv_if.err), 64'(exp_err));
         end
         if (k == 1) begin
            r = {$urandom, $urandom};
            conv_if.bcd = r[4*DIGITS-1:0];
         end
         if (poke) begin
            conv_if.start = (k == 2 || k == 9) ? 1'b1 : 1'b0;
            if (k == 2) conv_if.bcd = 36'h123456789;
         end
         step();
      end
      conv_if.start = 1'b0;
      check_val({tag, "_latency"}, 64'(done_at), 64'(LAT));
      check_val({tag, "_ndone"}, 64'(done_cnt), 64'd1);
      check_val({tag, "_busycyc"}, 64'(busy_cnt), 64'(DIGITS));
      check_val({tag, "_binheld"}, 64'(conv_if.bin), 64'(exp_val));
      check_val({tag, "_errheld"}, 64'(conv_if.err), 64'(exp_err));
   endtask

   initial begin
      logic [4*DIGITS-1:0] rb;
      int done_seen;
      int first_done;
      int second_done;
      bit prev_done;
      bit back_to_back;

      rst           = 1'b1;
      conv_if.start = 1'b0;
      conv_if.bcd   = '0;
      step();
      step();
      rst = 1'b0;
      check_val("rst_busy", 64'(conv_if.busy), 64'd0);
      check_val("rst_done", 64'(conv_if.done), 64'd0);
      check_val("rst_err",  64'(conv_if.err),  64'd0);
      check_val("rst_bin",  64'(conv_if.bin),  64'd0);
      step();

      run_conv("d561",  36'h000000561, 1'b0);
      run_conv("d9s",   36'h999999999, 1'b0);
      run_conv("dzero", 36'h000000000, 1'b0);
      run_conv("denter",36'h0000001D7, 1'b0);
      run_conv("d7",    36'h000000007, 1'b0);
      run_conv("dpoke", 36'h000000561, 1'b1);

      // Reset in the middle of a conversion.
      conv_if.bcd   = 36'h000000561;
      conv_if.start = 1'b1;
      step();
      conv_if.start = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_val("mrst_busy", 64'(conv_if.busy), 64'd0);
      check_val("mrst_done", 64'(conv_if.done), 64'd0);
      check_val("mrst_bin",  64'(conv_if.bin),  64'd0);
      check_val("mrst_err",  64'(conv_if.err),  64'd0);
      done_seen = 0;
      for (int k = 0; k < 15; k++) begin
         if (conv_if.done) done_seen++;
         step();
      end
      check_val("mrst_nodone", 64'(done_seen), 64'd0);
      run_conv("d13", 36'h000000013, 1'b0);

      // start held high: back-to-back conversions.
      conv_if.bcd   = 36'h000000042;
      conv_if.start = 1'b1;
      done_seen    = 0;
      first_done   = -1;
      second_done  = -1;
      prev_done    = 1'b0;
      back_to_back = 1'b0;
      for (int k = 0; k < 30; k++) begin
         step();
         if (conv_if.done) begin
            done_seen++;
            if (prev_done) back_to_back = 1'b1;
            if (first_done < 0) first_done = k;
            else if (second_done < 0) second_done = k;
            check_val("held_bin", 64'(conv_if.bin), 64'd42);
         end
         prev_done = conv_if.done;
      end
      conv_if.start = 1'b0;
      check_val("held_ndone", 64'(done_seen), 64'd2);
      check_val("held_first", 64'(first_done), 64'(LAT));
      check_val("held_interval", 64'(second_done - first_done), 64'(DIGITS + 2));
      check_val("held_no_b2b", 64'(back_to_back), 64'd0);
      repeat (15) step();

      // Randomized digit words, roughly one nibble in ten non-decimal.
      for (int n = 0; n < 20; n++) begin
         for (int i = 0; i < DIGITS; i++) begin
            if ($urandom_range(0, 9) == 0)
               rb[4*i +: 4] = 4'($urandom_range(10, 15));
            else
               rb[4*i +: 4] = 4'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 2) == 0) rb[4*DIGITS-1 -: 16] = 16'h0000;
         run_conv("rand", rb, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
